// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage pipelined floating-point multiplier, {sign, exp, frac} format.
// Stage 1 unpacks operands and multiplies the mantissas. Stage 2 normalises the product
// and derives the guard and sticky bits. Stage 3 rounds to nearest-even and packs the
// result, saturating on overflow and flushing to +0 on underflow.
// A single advance signal moves all stages together, so a stalled output freezes the pipe.
// Define FP_MUL_FLAGS_EN to add the registered out_ovf / out_unf status outputs.
module fp_mul_pipe #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_p,
  output logic         out_zero
`ifdef FP_MUL_FLAGS_EN
  ,
  output logic         out_ovf,
  output logic         out_unf
`endif
);
  localparam int EW   = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_MIN = EW'(1);

  logic                 advance;
  logic                 s1_valid_q, s2_valid_q, out_valid_q;

  logic                 s1_sign_d, s1_sign_q;
  logic                 s1_zero_d, s1_zero_q;
  logic signed [EW-1:0] s1_exp_d, s1_exp_q;
  logic [PW-1:0]        s1_prod_d, s1_prod_q;

  logic [PW-2:0]        s2_tail;
  logic                 s2_sign_d, s2_sign_q;
  logic                 s2_zero_d, s2_zero_q;
  logic signed [EW-1:0] s2_exp_d, s2_exp_q;
  logic [MAN_W-1:0]     s2_frac_d, s2_frac_q;
  logic                 s2_guard_d, s2_guard_q;
  logic                 s2_sticky_d, s2_sticky_q;

  logic                 round_up;
  logic [MAN_W:0]       frac_rnd;
  logic signed [EW-1:0] exp_rnd;
  logic                 is_ovf, is_unf;
  logic [W-1:0]         res_p_d, out_p_q;
  logic                 res_zero_d, out_zero_q;

  // Every stage moves when the output slot is empty or being consumed.
  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign out_zero  = out_zero_q;

  // Stage 1: sign, zero detect (exp field 0 flushes), biased exponent sum, mantissa product.
  always_comb begin
    s1_sign_d = in_a[W-1] ^ in_b[W-1];
    s1_zero_d = (in_a[W-2:MAN_W] == '0) || (in_b[W-2:MAN_W] == '0);
    s1_exp_d  = EW'(in_a[W-2:MAN_W]) + EW'(in_b[W-2:MAN_W]) - EW'(BIAS);
    s1_prod_d = PW'({1'b1, in_a[MAN_W-1:0]}) * PW'({1'b1, in_b[MAN_W-1:0]});
  end

  // Stage 2: product lies in [1,4); drop the hidden bit and keep the bits below it.
  always_comb begin
    s2_tail     = s1_prod_q[PW-1] ? s1_prod_q[PW-2:0] : {s1_prod_q[PW-3:0], 1'b0};
    s2_frac_d   = s2_tail[PW-2:MAN_W+1];
    s2_guard_d  = s2_tail[MAN_W];
    s2_sticky_d = |s2_tail[MAN_W-1:0];
    s2_exp_d    = s1_exp_q + EW'(s1_prod_q[PW-1]);
    s2_sign_d   = s1_sign_q;
    s2_zero_d   = s1_zero_q;
  end

  // Stage 3: round-to-nearest-even, renormalise on carry-out, then saturate or flush.
  always_comb begin
    round_up   = s2_guard_q && (s2_sticky_q || s2_frac_q[0]);
    frac_rnd   = {1'b0, s2_frac_q} + (MAN_W+1)'(round_up);
    exp_rnd    = s2_exp_q + EW'(frac_rnd[MAN_W]);
    is_ovf     = exp_rnd > EXP_MAX;
    is_unf     = exp_rnd < EXP_MIN;
    res_zero_d = s2_zero_q || is_unf;
    if (res_zero_d) begin
      res_p_d = '0;
    end else if (is_ovf) begin
      res_p_d = {s2_sign_q, {(W-1){1'b1}}};
    end else begin
      res_p_d = {s2_sign_q, exp_rnd[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
    end
  end

  // Valid bits shift together on advance; bubbles travel like data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (advance) begin
      s1_valid_q  <= in_valid;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
    end
  end

  // Stage 1 register: capture only on an accepted operand pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sign_q <= 1'b0;
      s1_zero_q <= 1'b0;
      s1_exp_q  <= '0;
      s1_prod_q <= '0;
    end else if (advance && in_valid) begin
      s1_sign_q <= s1_sign_d;
      s1_zero_q <= s1_zero_d;
      s1_exp_q  <= s1_exp_d;
      s1_prod_q <= s1_prod_d;
    end
  end

  // Stage 2 register: normalised fraction with rounding information.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_exp_q    <= '0;
      s2_frac_q   <= '0;
      s2_guard_q  <= 1'b0;
      s2_sticky_q <= 1'b0;
    end else if (advance && s1_valid_q) begin
      s2_sign_q   <= s2_sign_d;
      s2_zero_q   <= s2_zero_d;
      s2_exp_q    <= s2_exp_d;
      s2_frac_q   <= s2_frac_d;
      s2_guard_q  <= s2_guard_d;
      s2_sticky_q <= s2_sticky_d;
    end
  end

  // Output register: packed product and zero indication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_p_q    <= '0;
      out_zero_q <= 1'b0;
    end else if (advance && s2_valid_q) begin
      out_p_q    <= res_p_d;
      out_zero_q <= res_zero_d;
    end
  end

`ifdef FP_MUL_FLAGS_EN
  logic res_ovf_d, res_unf_d, out_ovf_q, out_unf_q;

  // A true-zero operand is neither an overflow nor an underflow.
  assign res_ovf_d = !s2_zero_q && is_ovf;
  assign res_unf_d = !s2_zero_q && is_unf;
  assign out_ovf   = out_ovf_q;
  assign out_unf   = out_unf_q;

  // Status flags registered alongside the product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_ovf_q <= 1'b0;
      out_unf_q <= 1'b0;
    end else if (advance && s2_valid_q) begin
      out_ovf_q <= res_ovf_d;
      out_unf_q <= res_unf_d;
    end
  end
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed vectors for fp_mul_pipe (E4M3 defaults) with a real-arithmetic
// reference model, a scoreboard compare on every output transfer, and literal expectations.
module tb_fp_mul_pipe;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [7:0] in_a, in_b, out_p;
`ifdef FP_MUL_FLAGS_EN
  logic       out_ovf, out_unf;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [7:0] p;
    logic       z;
    logic       ovf;
    logic       unf;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] p;
    logic       z;
    int         lat;
  } log_t;

  exp_t exp_q[$];
  log_t log_q[$];

  logic [7:0] va[8] = '{8'h48, 8'h30, 8'h7E, 8'h00, 8'h10, 8'h7E, 8'hFE, 8'h39};
  logic [7:0] vb[8] = '{8'h54, 8'hB8, 8'h10, 8'h10, 8'h10, 8'h7E, 8'h7E, 8'h3C};
  logic [7:0] ep[8] = '{8'h64, 8'hB0, 8'h56, 8'h00, 8'h00, 8'h7F, 8'hFF, 8'h3E};
  logic       ez[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  fp_mul_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_p    (out_p),
    .out_zero (out_zero)
`ifdef FP_MUL_FLAGS_EN
    ,
    .out_ovf  (out_ovf),
    .out_unf  (out_unf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: exact product as a real value, rounded ties-to-even to 1+3 mantissa bits.
  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] p, output logic z,
                                output logic ovf, output logic unf);
    int  ea, eb, e, qi, be;
    real r, fr;
    ea = int'(a[6:3]);
    eb = int'(b[6:3]);
    p = 8'h00; z = 1'b0; ovf = 1'b0; unf = 1'b0;
    if (ea == 0 || eb == 0) begin
      z = 1'b1;
      return;
    end
    // value = r * 2^e, with r the integer product of the 1.fff mantissas scaled by 8 each
    r = real'((8 + int'(a[2:0])) * (8 + int'(b[2:0])));
    e = (ea - 7) + (eb - 7) - 6;
    while (r >= 16.0) begin
      r = r / 2.0;
      e++;
    end
    qi = $rtoi(r);
    fr = r - real'(qi);
    if (fr > 0.5 || (fr == 0.5 && (qi % 2) == 1)) qi++;
    if (qi == 16) begin
      qi = 8;
      e++;
    end
    be = e + 3 + 7;
    if (be > 15) begin
      p   = {a[7] ^ b[7], 7'h7F};
      ovf = 1'b1;
    end else if (be < 1) begin
      z   = 1'b1;
      unf = 1'b1;
    end else begin
      p = {a[7] ^ b[7], 4'(be), 3'(qi - 8)};
    end
  endfunction

  // Compare process: scoreboard on output transfers, stall hold, ready rule.
  initial begin : monitor
    exp_t       e;
    exp_t       ne;
    log_t       l;
    logic       prev_stall;
    logic [7:0] prev_p;
    prev_stall = 1'b0;
    prev_p     = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
        if (prev_stall) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_hold_p", 32'(out_p), 32'(prev_p));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out: got out_p=0x%0h expected no result", out_p);
          end else begin
            e = exp_q.pop_front();
            chk("sb_p", 32'(out_p), 32'(e.p));
            chk("sb_zero", 32'(out_zero), 32'(e.z));
`ifdef FP_MUL_FLAGS_EN
            chk("sb_ovf", 32'(out_ovf), 32'(e.ovf));
            chk("sb_unf", 32'(out_unf), 32'(e.unf));
`endif
            l.p   = out_p;
            l.z   = out_zero;
            l.lat = cyc - e.cyc;
            log_q.push_back(l);
          end
        end
        if (in_valid && in_ready) begin
          model(in_a, in_b, ne.p, ne.z, ne.ovf, ne.unf);
          ne.cyc = cyc;
          exp_q.push_back(ne);
        end
        prev_stall = out_valid && !out_ready;
        prev_p     = out_p;
      end
    end
  end

  // Present one operand pair and hold it until the pipe accepts it.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    int k;
    bit done;
    k = 0;
    done = 1'b0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!done && k < 30) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      k++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: got no acceptance of 0x%0h x 0x%0h expected in_ready within 30 cycles", a, b);
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk({name, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected end of test before 200000");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int         base;
    logic [7:0] mp;
    logic       mz, mo, mu;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = 8'h00;
    in_b = 8'h00;
    out_ready = 1'b1;

    // Pin the reference model with hand-computed products.
    model(8'h39, 8'h3C, mp, mz, mo, mu);
    chk("model_tie", 32'(mp), 32'h3E);
    model(8'h10, 8'h10, mp, mz, mo, mu);
    chk("model_flush_zero", 32'(mz), 32'd1);
    chk("model_flush_unf", 32'(mu), 32'd1);
    model(8'h7E, 8'h7E, mp, mz, mo, mu);
    chk("model_sat", 32'(mp), 32'h7F);
    chk("model_sat_ovf", 32'(mo), 32'd1);
    model(8'h48, 8'h54, mp, mz, mo, mu);
    chk("model_basic", 32'(mp), 32'h64);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_p", 32'(out_p), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef FP_MUL_FLAGS_EN
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_out_unf", 32'(out_unf), 32'd0);
`endif
    rst = 1'b0;

    // Basic, zero/flush, saturation and tie vectors back to back
    base = log_q.size();
    for (int i = 0; i < 8; i++) issue(va[i], vb[i]);
    in_valid = 1'b0;
    drain("basic");
    chk("basic_count", 32'(log_q.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("basic_p_%0d", i), 32'(log_q[base+i].p), 32'(ep[i]));
      chk($sformatf("basic_zero_%0d", i), 32'(log_q[base+i].z), 32'(ez[i]));
      chk($sformatf("basic_lat_%0d", i), 32'(log_q[base+i].lat), 32'd3);
    end

    // Backpressure: out_ready low for 5 cycles while 4 products are issued
    base = log_q.size();
    fork
      begin
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      begin
        issue(8'h48, 8'h54);
        issue(8'h30, 8'hB8);
        issue(8'h7E, 8'h10);
        issue(8'h39, 8'h3C);
        in_valid = 1'b0;
      end
    join
    drain("bp");
    chk("bp_count", 32'(log_q.size() - base), 32'd4);
    chk("bp_p_0", 32'(log_q[base+0].p), 32'h64);
    chk("bp_p_1", 32'(log_q[base+1].p), 32'hB0);
    chk("bp_p_2", 32'(log_q[base+2].p), 32'h56);
    chk("bp_p_3", 32'(log_q[base+3].p), 32'h3E);

    // Reset with one result at the output and two more in flight
    issue(8'h7E, 8'h7E);
    issue(8'h10, 8'h10);
    issue(8'hFE, 8'h7E);
    in_valid = 1'b0;
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_p", 32'(out_p), 32'd0);
    chk("midrst_out_zero", 32'(out_zero), 32'd0);
`ifdef FP_MUL_FLAGS_EN
    chk("midrst_out_ovf", 32'(out_ovf), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("postrst_in_ready", 32'(in_ready), 32'd1);
    base = log_q.size();
    repeat (6) @(posedge clk);
    #1;
    chk("postrst_no_stale", 32'(log_q.size() - base), 32'd0);
    issue(8'h48, 8'h54);
    in_valid = 1'b0;
    drain("postrst");
    chk("postrst_count", 32'(log_q.size() - base), 32'd1);
    chk("postrst_p", 32'(log_q[base].p), 32'h64);
    chk("postrst_lat", 32'(log_q[base].lat), 32'd3);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
